// File: rtl/trng_apb_req_arbiter_pkg.sv
// Shared types and default register map for the TRNG APB request arbiter.
// The address defaults match the TRNG slave's register layout.
package trng_apb_req_arbiter_pkg;

    typedef enum logic [2:0] {
        INIT_SETUP,
        INIT_ACCESS,
        IDLE,
        STS_SETUP,
        STS_ACCESS,
        DAT_SETUP,
        DAT_ACCESS,
        RESP
    } state_t;

    localparam int          STATUS_VALID_BIT = 0;
    localparam int          POLL_CNT_W       = 8;

    localparam logic [31:0] DEF_CTRL_ADDR    = 32'h0000_0000;
    localparam logic [31:0] DEF_STATUS_ADDR  = 32'h0000_0004;
    localparam logic [31:0] DEF_DATA_ADDR    = 32'h0000_0008;
    localparam logic [31:0] DEF_CTRL_INIT    = 32'h0000_0001;

endpackage

// File: rtl/trng_apb_req_arbiter_rr_arbiter_n.sv
// Round-robin pick over NUM_REQ requests with a registered search pointer.
// The pointer moves to one past the winner only when the caller commits the grant.
module rr_arbiter_n #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] ptr;

    // Walk from the far end back toward ptr so the closest requester wins last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update) begin
            if (gnt_idx == IDX_W'(NUM_REQ - 1))
                ptr <= '0;
            else
                ptr <= gnt_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/trng_apb_req_arbiter.sv
// Sole APB master of the TRNG: enables it after reset, then serves consumer
// requests round-robin by polling STATUS and reading DATA.
module trng_apb_req_arbiter
    import trng_apb_req_arbiter_pkg::*;
#(
    parameter int          NUM_REQ          = 4,
    parameter int          APB_ADDR_WIDTH   = 32,
    parameter int          APB_DATA_WIDTH   = 32,
    parameter int          APB_STROBE_WIDTH = APB_DATA_WIDTH / 8,
    parameter logic [31:0] CTRL_ADDR        = DEF_CTRL_ADDR,
    parameter logic [31:0] STATUS_ADDR      = DEF_STATUS_ADDR,
    parameter logic [31:0] DATA_ADDR        = DEF_DATA_ADDR,
    parameter logic [31:0] CTRL_INIT        = DEF_CTRL_INIT,
    parameter int          POLL_LIMIT       = 255
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          ack,
    output logic [APB_DATA_WIDTH-1:0]   rdata,
    output logic                        err,
    output logic                        init_err,
    output logic [APB_ADDR_WIDTH-1:0]   paddr,
    output logic [APB_DATA_WIDTH-1:0]   pwdata,
    output logic [2:0]                  pprot,
    output logic                        psel,
    output logic                        penable,
    output logic                        pwrite,
    output logic [APB_STROBE_WIDTH-1:0] pstrb,
    input  logic                        pready,
    input  logic                        pslverr,
    input  logic [APB_DATA_WIDTH-1:0]   prdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                  state, state_nxt;
    logic                    armed;
    logic [IDX_W-1:0]        gnt_q;
    logic [IDX_W-1:0]        gnt_idx;
    logic                    gnt_any;
    logic                    grant;
    logic [POLL_CNT_W-1:0]   poll_cnt;
    logic                    resp_fire;
    logic                    resp_err;

    assign grant = (state == IDLE) && gnt_any;

    rr_arbiter_n #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (pclk),
        .rst     (preset),
        .req     (req),
        .update  (grant),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        state_nxt = state;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        case (state)
            INIT_SETUP:  if (armed) state_nxt = INIT_ACCESS;
            INIT_ACCESS: if (pready) state_nxt = IDLE;
            IDLE:        if (gnt_any) state_nxt = STS_SETUP;
            STS_SETUP:   state_nxt = STS_ACCESS;
            STS_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        state_nxt = RESP;
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                    end else if (prdata[STATUS_VALID_BIT]) begin
                        state_nxt = DAT_SETUP;
                    end else if (poll_cnt == POLL_CNT_W'(POLL_LIMIT - 1)) begin
                        // This read is the POLL_LIMIT-th one and still not valid.
                        state_nxt = RESP;
                        resp_fire = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        state_nxt = STS_SETUP;
                    end
                end
            end
            DAT_SETUP:   state_nxt = DAT_ACCESS;
            DAT_ACCESS: begin
                if (pready) begin
                    state_nxt = RESP;
                    resp_fire = 1'b1;
                    resp_err  = pslverr;
                end
            end
            RESP:        state_nxt = IDLE;
            default:     state_nxt = INIT_SETUP;
        endcase
    end

    // The bus stays idle for the first cycle out of reset, so a reset that
    // lands mid-transfer drops psel on the very next cycle.
    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        case (state)
            INIT_SETUP, INIT_ACCESS: begin
                if (armed || state == INIT_ACCESS) begin
                    psel    = 1'b1;
                    penable = (state == INIT_ACCESS);
                    pwrite  = 1'b1;
                    paddr   = APB_ADDR_WIDTH'(CTRL_ADDR);
                    pwdata  = APB_DATA_WIDTH'(CTRL_INIT);
                    pstrb   = '1;
                end
            end
            STS_SETUP, STS_ACCESS: begin
                psel    = 1'b1;
                penable = (state == STS_ACCESS);
                paddr   = APB_ADDR_WIDTH'(STATUS_ADDR);
            end
            DAT_SETUP, DAT_ACCESS: begin
                psel    = 1'b1;
                penable = (state == DAT_ACCESS);
                paddr   = APB_ADDR_WIDTH'(DATA_ADDR);
            end
            default: ;
        endcase
    end

    assign pprot = 3'b000;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= INIT_SETUP;
            armed    <= 1'b0;
            gnt_q    <= '0;
            poll_cnt <= '0;
            ack      <= '0;
            rdata    <= '0;
            err      <= 1'b0;
            init_err <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            ack   <= '0;
            err   <= 1'b0;
            if (grant) begin
                gnt_q    <= gnt_idx;
                poll_cnt <= '0;
            end else if (state == STS_ACCESS && pready) begin
                poll_cnt <= poll_cnt + POLL_CNT_W'(1);
            end
            if (resp_fire) begin
                ack   <= NUM_REQ'(1) << gnt_q;
                err   <= resp_err;
                rdata <= resp_err ? '0 : prdata;
            end
            if (state == INIT_ACCESS && pready && pslverr)
                init_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_trng_apb_req_arbiter.sv
// Directed bench: a behavioural TRNG slave plus a linear sequence of checks.
module tb_trng_apb_req_arbiter;

    logic        pclk = 1'b0;
    logic        preset;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [31:0] rdata;
    logic        err;
    logic        init_err;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int tests = 0;
    int fails = 0;

    // slave knobs, set by the sequence
    int          wait_states = 0;
    int          zero_n      = 0;
    int          st_base     = 0;
    logic [31:0] data_word   = 32'hDEADBEEF;
    logic        err_init    = 1'b0;
    logic        err_data    = 1'b0;

    // slave-side observations
    int          wcnt      = 0;
    int          st_reads  = 0;
    int          wr_cnt    = 0;
    int          ack_total = 0;
    logic [31:0] wr_addr   = '0;
    logic [31:0] wr_data   = '0;
    logic [3:0]  wr_strb   = '0;

    trng_apb_req_arbiter #(.NUM_REQ(4), .POLL_LIMIT(4)) dut (
        .pclk(pclk), .preset(preset), .req(req), .ack(ack), .rdata(rdata),
        .err(err), .init_err(init_err), .paddr(paddr), .pwdata(pwdata),
        .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    always_comb begin
        pready  = psel && penable && (wcnt >= wait_states);
        pslverr = pready && ((pwrite && err_init) || (!pwrite && paddr == 32'h8 && err_data));
        prdata  = '0;
        if (paddr == 32'h4)
            prdata = {31'b0, (st_reads - st_base) >= zero_n};
        else if (paddr == 32'h8)
            prdata = data_word;
    end

    always @(posedge pclk) begin
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
        if (pready && pwrite) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= paddr;
            wr_data <= pwdata;
            wr_strb <= pstrb;
        end
        if (pready && !pwrite && paddr == 32'h4) st_reads <= st_reads + 1;
        if (ack != 0) ack_total <= ack_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_init();
        int base = wr_cnt;
        int n = 0;
        while (wr_cnt == base && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("init_write_seen", 32'(wr_cnt != base), 32'd1);
    endtask

    // Raise req at a negedge while the DUT is idle; cyc = negedges to ack.
    task automatic run_req(input logic [3:0] r, output logic [3:0] a, output int cyc,
                           output logic [31:0] d, output logic e);
        req = r;
        cyc = 0;
        do begin
            @(negedge pclk);
            cyc++;
        end while (ack == 4'b0 && cyc < 200);
        a = ack;
        d = rdata;
        e = err;
        req = 4'b0;
        @(negedge pclk);
        chk("ack_one_cycle", {28'b0, ack}, 32'h0);
    endtask

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        logic        e;
        int          cyc;
        int          base;
        int          n;

        req    = 4'b0;
        preset = 1'b1;
        repeat (3) @(negedge pclk);
        chk("rst_ack",      {28'b0, ack},                 32'h0);
        chk("rst_psel",     {31'b0, psel},                32'h0);
        chk("rst_penable",  {31'b0, penable},             32'h0);
        chk("rst_pwrite",   {31'b0, pwrite},              32'h0);
        chk("rst_paddr",    paddr,                        32'h0);
        chk("rst_pstrb",    {28'b0, pstrb},               32'h0);
        chk("rst_misc",     {rdata[30:0], err, init_err}, 32'h0);
        chk("rst_pprot",    {29'b0, pprot},               32'h0);

        // Init write after reset release.
        preset = 1'b0;
        wait_init();
        chk("init_wr_cnt",  32'(wr_cnt),      32'd1);
        chk("init_addr",    wr_addr,          32'h0);
        chk("init_data",    wr_data,          32'h1);
        chk("init_strb",    {28'b0, wr_strb}, 32'hF);
        chk("init_psel_lo", {31'b0, psel},    32'h0);
        chk("init_err_lo",  {31'b0, init_err}, 32'h0);

        // All four held: round-robin 0,1,2,3,0.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            do begin
                @(negedge pclk);
                n++;
            end while (ack == 4'b0 && n < 200);
            chk("rr_order", {28'b0, ack}, 32'(1 << (k % 4)));
            if (k == 4) req = 4'b0;
            @(negedge pclk);
            chk("rr_ack_one_cycle", {28'b0, ack}, 32'h0);
        end

        // Single requester, zero-wait, valid on first poll: ack at t+5.
        run_req(4'b0001, a, cyc, d, e);
        chk("single_ack",   {28'b0, a}, 32'h1);
        chk("single_lat",   32'(cyc),   32'd5);
        chk("single_rdata", d,          32'hDEADBEEF);
        chk("single_err",   {31'b0, e}, 32'h0);
        chk("rdata_hold",   rdata,      32'hDEADBEEF);

        // Three invalid polls then valid: ack at t+11.
        st_base   = st_reads;
        zero_n    = 3;
        data_word = 32'h1234_5678;
        run_req(4'b0010, a, cyc, d, e);
        chk("poll3_ack",   {28'b0, a}, 32'h2);
        chk("poll3_lat",   32'(cyc),   32'd11);
        chk("poll3_rdata", d,          32'h1234_5678);
        chk("poll3_err",   {31'b0, e}, 32'h0);

        // STATUS stuck at 0 with POLL_LIMIT=4: timeout after 4 polls.
        st_base = st_reads;
        zero_n  = 1000;
        run_req(4'b1000, a, cyc, d, e);
        chk("tmo_ack",   {28'b0, a},          32'h8);
        chk("tmo_lat",   32'(cyc),            32'd9);
        chk("tmo_err",   {31'b0, e},          32'h1);
        chk("tmo_rdata", d,                   32'h0);
        chk("tmo_polls", 32'(st_reads - st_base), 32'd4);

        // pslverr on the DATA read.
        zero_n    = 0;
        err_data  = 1'b1;
        data_word = 32'hCAFE_F00D;
        run_req(4'b0100, a, cyc, d, e);
        chk("derr_ack",   {28'b0, a}, 32'h4);
        chk("derr_err",   {31'b0, e}, 32'h1);
        chk("derr_rdata", d,          32'h0);
        err_data = 1'b0;

        // Reset during a wait-stated DATA access.
        wait_states = 3;
        req = 4'b0001;
        n = 0;
        while (!(psel && penable && paddr == 32'h8) && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("dat_access_reached", 32'(n < 200), 32'd1);
        base   = ack_total;
        preset = 1'b1;
        @(negedge pclk);
        chk("midrst_psel", {31'b0, psel}, 32'h0);
        chk("midrst_ack",  {28'b0, ack},  32'h0);
        preset = 1'b0;
        req    = 4'b0;
        wait_init();
        chk("midrst_reinit_addr", wr_addr, 32'h0);
        chk("midrst_reinit_data", wr_data, 32'h1);
        chk("midrst_no_ack",      32'(ack_total - base), 32'd0);
        wait_states = 0;

        // pslverr on the init write: sticky init_err, requests still served.
        err_init = 1'b1;
        preset   = 1'b1;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        wait_init();
        err_init = 1'b0;
        @(negedge pclk);
        chk("init_err_set", {31'b0, init_err}, 32'h1);
        data_word = 32'h0BAD_5EED;
        run_req(4'b0100, a, cyc, d, e);
        chk("ierr_serve_ack",   {28'b0, a}, 32'h4);
        chk("ierr_serve_rdata", d,          32'h0BAD_5EED);
        chk("init_err_sticky",  {31'b0, init_err}, 32'h1);
        preset = 1'b1;
        @(negedge pclk);
        chk("init_err_cleared", {31'b0, init_err}, 32'h0);
        preset = 1'b0;
        wait_init();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
